pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS datapath. Per cycle it decides which pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) advance, hold or take a bubble. It resolves load-use and branch-operand hazards, squashes the wrong-path fetch after an ID-stage redirect, and selects EX operand forwarding. It also freezes the whole pipe while data memory is busy, with a watchdog timeout.

## Interface

Parameters:
- TIMEOUT, 255: maximum MWAIT cycles before the error trap.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  main clock; all state changes on the rising edge.
- cpu_rst_n  in  1  asynchronous active-low reset.
- cpu_en  in  1  global step enable; 0 freezes everything, state included.
- id_addr_rs, id_addr_rt  in  5  source registers of the instruction in ID.
- id_use_rs, id_use_rt  in  1  the ID instruction reads rs / rt.
- id_is_cmp  in  1  the ID instruction is a BEQ/BNE/JR, which reads registers in ID.
- id_redirect  in  1  the ID-stage branch/jump is taken (PC loads the target).
- ex_addr_rs, ex_addr_rt  in  5  source registers of the instruction in EX.
- ex_regw_addr  in  5  destination register of EX; ex_wb_wen, ex_mem_ren  in  1.
- mem_regw_addr  in  5  destination register of MEM; mem_wb_wen, mem_mem_ren  in  1.
- wb_regw_addr  in  5  destination register of WB; wb_wb_wen  in  1.
- mem_req  in  1  the MEM stage accesses data memory (ren|wen).
- mem_ack  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  register write enables.
- if_id_flush  out  1  load a NOP into IF/ID when enabled.
- id_ex_bubble  out  1  load a NOP (all ctrl 0) into ID/EX when enabled.
- fwd_a, fwd_b  out  2  EX operand select: 00 register file, 01 EX/MEM aluout, 10 MEM/WB data.
- mem_err  out  1  sticky watchdog error.
- stall_cnt  out  CNT_W  count of cycles in which pc_en=0 while cpu_en=1, saturating.

## Operation

- **FSM states:** RUN, MWAIT, ERR. Reset state is RUN.
- **"Match" definition:** a source register matches a destination only when the destination address is nonzero, the stage's wb_wen=1, and the addresses are equal.
- **Load-use stall (RUN):** ex_mem_ren and the EX destination matches a used ID source → stall.
- **Branch-operand stall (RUN):** id_is_cmp and the EX destination matches a used ID source (any writer) → stall. Also id_is_cmp and mem_mem_ren and the MEM destination matches → stall.
- **Stall action:**
  - pc_en=0, if_id_en=0.
  - id_ex_bubble=1 with id_ex_en=1.
  - ex_mem_en=1, mem_wb_en=1.
  - id_redirect is ignored during a stall; the branch re-evaluates next cycle.
- **Redirect (RUN, no stall, id_redirect=1):** all enables 1, if_id_flush=1 (one wrong-path fetch squashed; no delay slot).
- **Memory wait:**
  - In RUN, mem_req=1 and mem_ack=0 → go to MWAIT. All five enables are 0 in that same cycle and for every MWAIT cycle.
  - In MWAIT, mem_ack=1 → return to RUN. Enables in that ack cycle follow the RUN rules.
  - Memory freeze overrides the hazard stall and the redirect; flush and bubble are 0 while frozen.
- **Watchdog:** the wait counter clears on entering MWAIT and increments each MWAIT cycle. Reaching TIMEOUT without an ack → ERR.
- **ERR:** all enables 0, mem_err=1; exit only by reset.
- **Forwarding (combinational, any state), fwd_a for ex_addr_rs:**
  - 01 if it matches the MEM destination and mem_mem_ren=0.
  - Otherwise 10 if it matches the WB destination.
  - Otherwise 00.
  - MEM has priority over WB. fwd_b is the same rule on ex_addr_rt.
- **cpu_en=0:** all enables 0, flush/bubble 0, FSM, watchdog and stall_cnt hold. Forwarding outputs are still driven.

## Timing

- **Reset values (asynchronous, immediate on cpu_rst_n=0):**
  - all enables 0, if_id_flush 0, id_ex_bubble 0;
  - mem_err 0, stall_cnt 0, fwd_a/fwd_b 00;
  - state RUN, watchdog 0.
- **Reset mid-MWAIT or in ERR:** returns to RUN and clears mem_err.
- **Decode latency:** enables, flush, bubble and fwd are combinational from the current state and inputs, with zero-cycle decode.
- **Registered state:** FSM state, watchdog, mem_err and stall_cnt update on the clock edge.
- **Load-use:** costs exactly 1 stall cycle (the load then reaches MEM and data is forwarded from WB).
- **Branch-operand hazards:** a dependency on an EX ALU writer costs 1 cycle; a dependency on a load in EX costs 2 cycles.
- **Simultaneous events:**
  - mem_req with !mem_ack plus a hazard: freeze only.
  - Stall plus redirect: stall only.
  - mem_ack arriving on the TIMEOUT-th cycle: ack wins, go to RUN.
- **stall_cnt:** sticks at 2^CNT_W-1.

## Test plan

- **Load-use:** EX = lw $3 (ex_mem_ren=1, wb_wen=1, ex_regw_addr=3), ID reads rs=3 → for 1 cycle pc_en=0, if_id_en=0, id_ex_bubble=1; the next cycle is normal with fwd_a=10 once the load is in WB; stall_cnt=1.
- **Taken branch:** id_redirect=1 with no hazard → if_id_flush=1, all enables 1, exactly one cycle. The same stimulus with an EX writer of $5 while the ID BEQ reads $5 → stall 1 cycle first, then flush.
- **Forward priority:** MEM dest=7 (ALU), WB dest=7, EX rs=7, rt=0 → fwd_a=01, fwd_b=00. With destination $0 → 00.
- **Memory wait:** mem_req=1, mem_ack=0 for 3 cycles then 1 → enables 0 for 3 cycles, RUN on the 4th, stall_cnt=3.
- **Watchdog:** TIMEOUT=4, no ack → mem_err=1 after 4 MWAIT cycles, enables stay 0. Assert cpu_rst_n=0 mid-ERR → mem_err=0 and RUN immediately.
- **cpu_en=0 during MWAIT:** state and watchdog hold; on re-enable the count resumes from the held value.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline hazard/status inputs and the register
// enables, bubble/flush, forwarding selects and status it returns.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             cpu_en;
  logic [4:0]       id_addr_rs;
  logic [4:0]       id_addr_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_is_cmp;
  logic             id_redirect;
  logic [4:0]       ex_addr_rs;
  logic [4:0]       ex_addr_rt;
  logic [4:0]       ex_regw_addr;
  logic             ex_wb_wen;
  logic             ex_mem_ren;
  logic [4:0]       mem_regw_addr;
  logic             mem_wb_wen;
  logic             mem_mem_ren;
  logic [4:0]       wb_regw_addr;
  logic             wb_wb_wen;
  logic             mem_req;
  logic             mem_ack;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output cpu_en, id_addr_rs, id_addr_rt, id_use_rs, id_use_rt, id_is_cmp,
           id_redirect, ex_addr_rs, ex_addr_rt, ex_regw_addr, ex_wb_wen,
           ex_mem_ren, mem_regw_addr, mem_wb_wen, mem_mem_ren, wb_regw_addr,
           wb_wb_wen, mem_req, mem_ack,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
           id_ex_bubble, fwd_a, fwd_b, mem_err, stall_cnt
  );

  modport slave (
    input  cpu_en, id_addr_rs, id_addr_rt, id_use_rs, id_use_rt, id_is_cmp,
           id_redirect, ex_addr_rs, ex_addr_rt, ex_regw_addr, ex_wb_wen,
           ex_mem_ren, mem_regw_addr, mem_wb_wen, mem_mem_ren, wb_regw_addr,
           wb_wb_wen, mem_req, mem_ack,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
           id_ex_bubble, fwd_a, fwd_b, mem_err, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for the 5-stage MIPS pipe: hazard stalls, redirect
// squash, EX forwarding, and a memory-wait freeze guarded by a watchdog.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input logic              clk,
  input logic              cpu_rst_n,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_RUN, S_MWAIT, S_ERR} state_e;

  state_e           state_q;
  logic [WD_W-1:0]  wd_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic ex_hit, mem_hit, load_use, br_stall, hazard, freeze, go;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_bubble;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst,
                                     input logic wen);
    return wen && (dst != 5'd0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (reg_match(src, bus.mem_regw_addr, bus.mem_wb_wen) && !bus.mem_mem_ren)
      return 2'b01;
    else if (reg_match(src, bus.wb_regw_addr, bus.wb_wb_wen))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ex_hit   = (bus.id_use_rs && reg_match(bus.id_addr_rs, bus.ex_regw_addr, bus.ex_wb_wen))
            || (bus.id_use_rt && reg_match(bus.id_addr_rt, bus.ex_regw_addr, bus.ex_wb_wen));
    mem_hit  = (bus.id_use_rs && reg_match(bus.id_addr_rs, bus.mem_regw_addr, bus.mem_wb_wen))
            || (bus.id_use_rt && reg_match(bus.id_addr_rt, bus.mem_regw_addr, bus.mem_wb_wen));
    load_use = bus.ex_mem_ren && ex_hit;
    br_stall = bus.id_is_cmp && (ex_hit || (bus.mem_mem_ren && mem_hit));
    hazard   = load_use || br_stall;

    // The ack cycle of a wait is treated as a normal RUN cycle.
    freeze = (state_q == S_ERR)
          || (state_q == S_MWAIT && !bus.mem_ack)
          || (state_q == S_RUN && bus.mem_req && !bus.mem_ack);
    go     = bus.cpu_en && cpu_rst_n && !freeze;

    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (go) begin
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (hazard) begin
        id_ex_bubble = 1'b1;
      end else begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = bus.id_redirect;
      end
    end

    fwd_a = cpu_rst_n ? fwd_sel(bus.ex_addr_rs) : 2'b00;
    fwd_b = cpu_rst_n ? fwd_sel(bus.ex_addr_rt) : 2'b00;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= S_RUN;
      wd_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (bus.cpu_en) begin
      case (state_q)
        S_RUN: begin
          if (bus.mem_req && !bus.mem_ack) begin
            state_q <= S_MWAIT;
            wd_q    <= '0;
          end
        end
        S_MWAIT: begin
          if (bus.mem_ack) begin
            state_q <= S_RUN;
          end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: state_q <= S_ERR;
      endcase
      if (!pc_en && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.id_ex_en     = id_ex_en;
  assign bus.ex_mem_en    = ex_mem_en;
  assign bus.mem_wb_en    = mem_wb_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.fwd_a        = fwd_a;
  assign bus.fwd_b        = fwd_b;
  assign bus.mem_err      = err_q;
  assign bus.stall_cnt    = cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with TIMEOUT=4 and a 3-bit stall counter
// so watchdog expiry and counter saturation are reached in a few cycles.
module tb_pipe_hazard_ctrl;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 3;

  // {pc, if_id, id_ex, ex_mem, mem_wb, flush, bubble}
  localparam logic [6:0] EN_RUN   = 7'b11111_00;
  localparam logic [6:0] EN_STALL = 7'b00111_01;
  localparam logic [6:0] EN_REDIR = 7'b11111_10;
  localparam logic [6:0] EN_ZERO  = 7'b00000_00;

  logic clk = 1'b0;
  logic cpu_rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .cpu_rst_n (cpu_rst_n),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  logic [6:0] ctrl;
  assign ctrl = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                 bus.if_id_flush, bus.id_ex_bubble};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cpu_en        = 1'b1;
    bus.id_addr_rs    = '0;
    bus.id_addr_rt    = '0;
    bus.id_use_rs     = 1'b0;
    bus.id_use_rt     = 1'b0;
    bus.id_is_cmp     = 1'b0;
    bus.id_redirect   = 1'b0;
    bus.ex_addr_rs    = '0;
    bus.ex_addr_rt    = '0;
    bus.ex_regw_addr  = '0;
    bus.ex_wb_wen     = 1'b0;
    bus.ex_mem_ren    = 1'b0;
    bus.mem_regw_addr = '0;
    bus.mem_wb_wen    = 1'b0;
    bus.mem_mem_ren   = 1'b0;
    bus.wb_regw_addr  = '0;
    bus.wb_wb_wen     = 1'b0;
    bus.mem_req       = 1'b0;
    bus.mem_ack       = 1'b0;
  endtask

  task automatic do_reset();
    cpu_rst_n = 1'b0;
    #1;
    cpu_rst_n = 1'b1;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    // Reset with inputs that would otherwise forward and freeze
    cpu_rst_n = 1'b0;
    idle();
    bus.mem_regw_addr = 5'd7; bus.mem_wb_wen = 1'b1; bus.ex_addr_rs = 5'd7; bus.mem_req = 1'b1;
    #2;
    check("rst_ctrl", 32'(ctrl), 32'(EN_ZERO));
    check("rst_fwd", 32'({bus.fwd_a, bus.fwd_b}), 32'd0);
    check("rst_err", 32'(bus.mem_err), 32'd0);
    check("rst_cnt", 32'(bus.stall_cnt), 32'd0);
    tick();
    cpu_rst_n = 1'b1;
    idle();
    #1 check("run_idle", 32'(ctrl), 32'(EN_RUN));

    // Load-use: lw $3 in EX, ID reads $3
    bus.ex_regw_addr = 5'd3; bus.ex_wb_wen = 1'b1; bus.ex_mem_ren = 1'b1;
    bus.id_addr_rs = 5'd3; bus.id_use_rs = 1'b1;
    #1 check("lu_stall", 32'(ctrl), 32'(EN_STALL));
    tick();
    check("lu_cnt", 32'(bus.stall_cnt), 32'd1);
    idle();
    bus.mem_regw_addr = 5'd3; bus.mem_wb_wen = 1'b1; bus.mem_mem_ren = 1'b1;
    bus.id_addr_rs = 5'd3; bus.id_use_rs = 1'b1;
    #1 check("lu_resume", 32'(ctrl), 32'(EN_RUN));
    tick();
    idle();
    bus.wb_regw_addr = 5'd3; bus.wb_wb_wen = 1'b1; bus.ex_addr_rs = 5'd3;
    #1 check("lu_fwd", 32'(bus.fwd_a), 32'd2);
    check("lu_fwd_ctrl", 32'(ctrl), 32'(EN_RUN));
    tick();
    check("lu_cnt_hold", 32'(bus.stall_cnt), 32'd1);

    // Load-use corner cases, combinational only
    idle();
    bus.ex_regw_addr = 5'd3; bus.ex_wb_wen = 1'b1; bus.ex_mem_ren = 1'b1;
    bus.id_addr_rt = 5'd3; bus.id_use_rt = 1'b1;
    #1 check("lu_rt", 32'(ctrl), 32'(EN_STALL));
    bus.id_use_rt = 1'b0; bus.id_addr_rs = 5'd3;
    #1 check("lu_unused", 32'(ctrl), 32'(EN_RUN));
    bus.ex_regw_addr = 5'd0; bus.id_addr_rs = 5'd0; bus.id_use_rs = 1'b1;
    #1 check("lu_r0", 32'(ctrl), 32'(EN_RUN));
    bus.ex_regw_addr = 5'd3; bus.id_addr_rs = 5'd3; bus.ex_wb_wen = 1'b0;
    #1 check("lu_nowen", 32'(ctrl), 32'(EN_RUN));
    idle();

    // Taken branch, no hazard
    bus.id_redirect = 1'b1;
    #1 check("br_taken", 32'(ctrl), 32'(EN_REDIR));
    tick();
    idle();
    #1 check("br_after", 32'(ctrl), 32'(EN_RUN));

    // BEQ reads $5 written by an ALU op in EX: 1 stall then redirect
    bus.ex_regw_addr = 5'd5; bus.ex_wb_wen = 1'b1;
    bus.id_is_cmp = 1'b1; bus.id_addr_rs = 5'd5; bus.id_use_rs = 1'b1; bus.id_redirect = 1'b1;
    #1 check("br_alu_stall", 32'(ctrl), 32'(EN_STALL));
    tick();
    bus.ex_regw_addr = 5'd0; bus.ex_wb_wen = 1'b0;
    bus.mem_regw_addr = 5'd5; bus.mem_wb_wen = 1'b1;
    #1 check("br_alu_go", 32'(ctrl), 32'(EN_REDIR));
    tick();

    // BEQ reads $6 loaded by lw in EX: 2 stalls then redirect
    idle();
    bus.ex_regw_addr = 5'd6; bus.ex_wb_wen = 1'b1; bus.ex_mem_ren = 1'b1;
    bus.id_is_cmp = 1'b1; bus.id_addr_rt = 5'd6; bus.id_use_rt = 1'b1; bus.id_redirect = 1'b1;
    #1 check("br_ld_s1", 32'(ctrl), 32'(EN_STALL));
    tick();
    bus.ex_regw_addr = 5'd0; bus.ex_wb_wen = 1'b0; bus.ex_mem_ren = 1'b0;
    bus.mem_regw_addr = 5'd6; bus.mem_wb_wen = 1'b1; bus.mem_mem_ren = 1'b1;
    #1 check("br_ld_s2", 32'(ctrl), 32'(EN_STALL));
    tick();
    bus.mem_regw_addr = 5'd0; bus.mem_wb_wen = 1'b0; bus.mem_mem_ren = 1'b0;
    bus.wb_regw_addr = 5'd6; bus.wb_wb_wen = 1'b1;
    #1 check("br_ld_go", 32'(ctrl), 32'(EN_REDIR));
    tick();
    check("br_cnt", 32'(bus.stall_cnt), 32'd4);

    // Non-compare consumer of an ALU result does not stall
    idle();
    bus.ex_regw_addr = 5'd5; bus.ex_wb_wen = 1'b1;
    bus.id_addr_rs = 5'd5; bus.id_use_rs = 1'b1;
    #1 check("alu_nostall", 32'(ctrl), 32'(EN_RUN));

    // Forwarding priority and $0
    idle();
    bus.mem_regw_addr = 5'd7; bus.mem_wb_wen = 1'b1;
    bus.wb_regw_addr = 5'd7; bus.wb_wb_wen = 1'b1;
    bus.ex_addr_rs = 5'd7; bus.ex_addr_rt = 5'd0;
    #1 check("fwd_mem_pri", 32'(bus.fwd_a), 32'd1);
    check("fwd_b_none", 32'(bus.fwd_b), 32'd0);
    bus.mem_mem_ren = 1'b1;
    #1 check("fwd_mem_load", 32'(bus.fwd_a), 32'd2);
    bus.mem_mem_ren = 1'b0; bus.mem_regw_addr = 5'd0; bus.wb_regw_addr = 5'd0; bus.ex_addr_rs = 5'd0;
    #1 check("fwd_r0", 32'(bus.fwd_a), 32'd0);
    bus.wb_regw_addr = 5'd9; bus.ex_addr_rt = 5'd9;
    #1 check("fwd_b_wb", 32'(bus.fwd_b), 32'd2);
    bus.wb_wb_wen = 1'b0;
    #1 check("fwd_b_nowen", 32'(bus.fwd_b), 32'd0);

    // Memory wait of 3 frozen cycles, freeze overriding hazard and redirect
    do_reset();
    check("mw_cnt0", 32'(bus.stall_cnt), 32'd0);
    bus.mem_req = 1'b1; bus.id_redirect = 1'b1;
    bus.ex_regw_addr = 5'd3; bus.ex_wb_wen = 1'b1; bus.ex_mem_ren = 1'b1;
    bus.id_addr_rs = 5'd3; bus.id_use_rs = 1'b1;
    #1 check("mw_entry", 32'(ctrl), 32'(EN_ZERO));
    tick();
    for (int i = 0; i < 2; i++) begin
      #1 check("mw_wait", 32'(ctrl), 32'(EN_ZERO));
      tick();
    end
    bus.mem_ack = 1'b1;
    bus.ex_regw_addr = 5'd0; bus.ex_wb_wen = 1'b0; bus.ex_mem_ren = 1'b0;
    #1 check("mw_ack", 32'(ctrl), 32'(EN_REDIR));
    tick();
    check("mw_cnt", 32'(bus.stall_cnt), 32'd3);
    idle();
    #1 check("mw_run", 32'(ctrl), 32'(EN_RUN));
    tick();

    // Ack on the TIMEOUT-th wait cycle wins over the watchdog
    do_reset();
    bus.mem_req = 1'b1;
    tick();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    bus.mem_ack = 1'b1;
    #1 check("wd_ack_last", 32'(ctrl), 32'(EN_RUN));
    tick();
    check("wd_ack_noerr", 32'(bus.mem_err), 32'd0);
    idle();
    #1 check("wd_ack_run", 32'(ctrl), 32'(EN_RUN));
    tick();

    // Watchdog expiry, counter saturation, reset out of ERR
    do_reset();
    bus.mem_req = 1'b1;
    tick();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("wd_pre", 32'(bus.mem_err), 32'd0);
    tick();
    check("wd_err", 32'(bus.mem_err), 32'd1);
    bus.mem_req = 1'b0; bus.mem_ack = 1'b1;
    #1 check("wd_err_hold", 32'(ctrl), 32'(EN_ZERO));
    for (int i = 0; i < 5; i++) tick();
    check("cnt_sat", 32'(bus.stall_cnt), 32'd7);
    cpu_rst_n = 1'b0;
    #1 check("wd_rst_err", 32'(bus.mem_err), 32'd0);
    check("wd_rst_cnt", 32'(bus.stall_cnt), 32'd0);
    cpu_rst_n = 1'b1;
    idle();
    #1 check("wd_rst_run", 32'(ctrl), 32'(EN_RUN));
    tick();

    // cpu_en=0 during MWAIT holds state, watchdog and counter
    do_reset();
    bus.mem_req = 1'b1;
    tick();
    tick();
    bus.cpu_en = 1'b0; bus.mem_ack = 1'b1;
    bus.mem_regw_addr = 5'd4; bus.mem_wb_wen = 1'b1; bus.ex_addr_rs = 5'd4;
    #1 check("en0_ctrl", 32'(ctrl), 32'(EN_ZERO));
    check("en0_fwd", 32'(bus.fwd_a), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check("en0_cnt", 32'(bus.stall_cnt), 32'd2);
    idle();
    #1 check("en1_wait", 32'(ctrl), 32'(EN_ZERO));
    tick();
    tick();
    check("en1_pre", 32'(bus.mem_err), 32'd0);
    tick();
    check("en1_err", 32'(bus.mem_err), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
